pipe_hazard_ctrl: RTL and testbench

Pipeline control unit for the 16-bit five-stage CPU (IF, ID, EX, MEM, WB). It watches the decoded opcode and register fields in ID and the destination fields in EX/MEM/WB. From these it generates per-stage enables and flushes, a one-bubble load-use stall, the branch-taken flush, registered forwarding selects for the EX operand muxes, and a start/halt/drain sequence. It also keeps a saturating bubble counter for performance checks.

---
 rtl/cpu_defs_pkg.sv | 12 +
 rtl/fwd_select.sv | 15 +
 rtl/pipe_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// cpu_defs: opcodes, pipeline-control states and forwarding selects shared across the CPU
package cpu_defs;
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_BZ    = 5'b11000;
  localparam logic [4:0] OP_BN    = 5'b11001;
  localparam logic [4:0] OP_JUMP  = 5'b10000;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;
  typedef enum logic [1:0] {FWD_GR = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10} fwd_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: newest-producer priority match choosing the EX operand source for one register
module fwd_select
  import cpu_defs::*;
(
  input  logic [2:0] src,
  input  logic       ex_wr,
  input  logic [2:0] ex_rd,
  input  logic       ex_load,
  input  logic       mem_wr,
  input  logic [2:0] mem_rd,
  output fwd_t       sel
);
  assign sel = (ex_wr && ex_rd == src && !ex_load) ? FWD_EXMEM :
               (mem_wr && mem_rd == src)           ? FWD_MEMWB : FWD_GR;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stage enables/flushes, load-use stall, branch flush, forwarding and halt drain
module pipe_hazard_ctrl
  import cpu_defs::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  id_opcode,
  input  logic [2:0]  id_ra,
  input  logic [2:0]  id_rb,
  input  logic        id_ra_used,
  input  logic        id_rb_used,
  input  logic [4:0]  ex_opcode,
  input  logic [2:0]  ex_rd,
  input  logic [2:0]  mem_rd,
  input  logic [2:0]  wb_rd,
  input  logic        ex_wr,
  input  logic        mem_wr,
  input  logic        wb_wr,
  input  logic        ex_branch_taken,
  output logic        if_en,
  output logic        id_en,
  output logic        id_flush,
  output logic        ex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        halted,
  output logic [15:0] bubble_count
);
  state_t state, state_n;
  fwd_t sel_a, sel_b;
  logic [1:0] drain_cnt, cnt_n, inc;
  logic [16:0] bc_sum;
  logic ex_load, load_use, br;
  assign ex_load = ex_opcode == OP_LOAD;
  assign load_use = ex_load && ex_wr &&
                    ((id_ra_used && id_ra == ex_rd) || (id_rb_used && id_rb == ex_rd));
  // an older branch resolving in DRAIN overrides the pending HALT
  assign br = ex_branch_taken && (state == S_RUN || state == S_DRAIN);
  assign bc_sum = {1'b0, bubble_count} + {15'd0, inc};
  fwd_select u_fwd_a (.src(id_ra), .ex_wr(ex_wr), .ex_rd(ex_rd), .ex_load(ex_load),
                      .mem_wr(mem_wr), .mem_rd(mem_rd), .sel(sel_a));
  fwd_select u_fwd_b (.src(id_rb), .ex_wr(ex_wr), .ex_rd(ex_rd), .ex_load(ex_load),
                      .mem_wr(mem_wr), .mem_rd(mem_rd), .sel(sel_b));
  always_comb begin
    state_n  = state;
    cnt_n    = drain_cnt;
    if_en    = 1'b0;
    id_en    = 1'b0;
    id_flush = 1'b0;
    ex_flush = 1'b0;
    inc      = 2'd0;
    if (br) begin
      state_n  = S_RUN;
      if_en    = 1'b1;
      id_en    = 1'b1;
      id_flush = 1'b1;
      ex_flush = 1'b1;
      inc      = 2'd2;
    end else begin
      case (state)
        S_IDLE: begin
          id_flush = 1'b1;
          ex_flush = 1'b1;
          state_n  = start ? S_RUN : S_IDLE;
        end
        S_RUN: begin
          if (load_use) begin
            ex_flush = 1'b1;
            inc      = 2'd1;
          end else if (id_opcode == OP_HALT) begin
            id_en   = 1'b1;
            state_n = S_DRAIN;
            cnt_n   = 2'd3;
          end else begin
            if_en = 1'b1;
            id_en = 1'b1;
          end
        end
        S_DRAIN: begin
          id_en    = 1'b1;
          id_flush = 1'b1;
          cnt_n    = drain_cnt == 2'd0 ? 2'd0 : drain_cnt - 2'd1;
          state_n  = drain_cnt <= 2'd1 ? S_HALTED : S_DRAIN;
        end
        default: state_n = start ? S_RUN : S_HALTED;
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      drain_cnt    <= 2'd0;
      fwd_a        <= FWD_GR;
      fwd_b        <= FWD_GR;
      halted       <= 1'b0;
      bubble_count <= 16'd0;
    end else begin
      state        <= state_n;
      drain_cnt    <= cnt_n;
      fwd_a        <= (id_en && !ex_flush) ? sel_a : FWD_GR;
      fwd_b        <= (id_en && !ex_flush) ? sel_b : FWD_GR;
      halted       <= state_n == S_HALTED;
      bubble_count <= bc_sum[16] ? 16'hFFFF : bc_sum[15:0];
    end
  end
  // write-before-read register file: a WB-only producer must be read from gr
  always_comb begin
    if (reset && wb_wr && wb_rd == id_ra && !(ex_wr && ex_rd == id_ra) && !(mem_wr && mem_rd == id_ra))
      assert (sel_a == FWD_GR);
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with hand-computed expectations for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  import cpu_defs::*;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic [4:0] id_opcode, ex_opcode;
  logic [2:0] id_ra, id_rb, ex_rd, mem_rd, wb_rd;
  logic id_ra_used, id_rb_used, ex_wr, mem_wr, wb_wr, ex_branch_taken;
  logic if_en, id_en, id_flush, ex_flush, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] bubble_count;
  int total = 0, bad = 0;
  pipe_hazard_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .id_opcode(id_opcode), .id_ra(id_ra),
    .id_rb(id_rb), .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .ex_opcode(ex_opcode),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_wr(ex_wr), .mem_wr(mem_wr),
    .wb_wr(wb_wr), .ex_branch_taken(ex_branch_taken), .if_en(if_en), .id_en(id_en),
    .id_flush(id_flush), .ex_flush(ex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .halted(halted), .bubble_count(bubble_count)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic ctl(input string tag, input logic ife, input logic ide, input logic idf, input logic exf);
    #1;
    check({tag, ".if_en"}, if_en, ife);
    check({tag, ".id_en"}, id_en, ide);
    check({tag, ".id_flush"}, id_flush, idf);
    check({tag, ".ex_flush"}, ex_flush, exf);
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic quiet();
    start = 1'b0; id_opcode = OP_NOP; ex_opcode = OP_NOP;
    id_ra = 3'd1; id_rb = 3'd2; ex_rd = 3'd6; mem_rd = 3'd7; wb_rd = 3'd7;
    id_ra_used = 1'b0; id_rb_used = 1'b0; ex_wr = 1'b0; mem_wr = 1'b0; wb_wr = 1'b0;
    ex_branch_taken = 1'b0;
  endtask
  task automatic load_use_in();
    ex_opcode = OP_LOAD; ex_wr = 1'b1; ex_rd = 3'd3;
    id_ra = 3'd3; id_rb = 3'd2; id_ra_used = 1'b1; id_rb_used = 1'b1;
  endtask
  initial begin
    quiet();
    step(); step();
    ctl("rst_hold", 0, 0, 1, 1);
    check("rst_fwd_a", fwd_a, 2'b00);
    check("rst_halted", halted, 0);
    check("rst_bc", bubble_count, 0);
    reset = 1'b1;
    step();
    ctl("idle", 0, 0, 1, 1);
    start = 1'b1; step(); start = 1'b0;
    ctl("run", 1, 1, 0, 0);
    load_use_in();
    ctl("lu_stall", 0, 0, 0, 1);
    step();
    check("lu_bc", bubble_count, 1);
    check("lu_fwd_clr", fwd_a, 2'b00);
    quiet(); id_ra = 3'd3; mem_wr = 1'b1; mem_rd = 3'd3;
    ctl("lu_after", 1, 1, 0, 0);
    step();
    check("lu_fwd_a", fwd_a, 2'b10);
    check("lu_fwd_b", fwd_b, 2'b00);
    check("lu_bc2", bubble_count, 1);
    quiet(); load_use_in(); ex_branch_taken = 1'b1;
    ctl("br_lu", 1, 1, 1, 1);
    step();
    check("br_bc", bubble_count, 3);
    check("br_fwd_clr", fwd_a, 2'b00);
    quiet(); ex_opcode = 5'b00100; ex_wr = 1'b1; ex_rd = 3'd5; mem_wr = 1'b1; mem_rd = 3'd5;
    id_rb = 3'd5; id_rb_used = 1'b1;
    ctl("fwd_run", 1, 1, 0, 0);
    step();
    check("fwd_b_ex", fwd_b, 2'b01);
    check("fwd_a_none", fwd_a, 2'b00);
    ex_wr = 1'b0;
    step();
    check("fwd_b_mem", fwd_b, 2'b10);
    ex_wr = 1'b1; ex_rd = 3'd0; id_ra = 3'd0;
    step();
    check("fwd_a_r0", fwd_a, 2'b01);
    check("fwd_b_r0", fwd_b, 2'b10);
    quiet(); ex_opcode = OP_LOAD; ex_wr = 1'b1; ex_rd = 3'd4; id_ra = 3'd4;
    mem_wr = 1'b1; mem_rd = 3'd4;
    ctl("ld_unused", 1, 1, 0, 0);
    step();
    check("fwd_a_ld_mem", fwd_a, 2'b10);
    check("ld_unused_bc", bubble_count, 3);
    quiet(); id_opcode = OP_HALT;
    ctl("halt", 0, 1, 0, 0);
    step();
    id_opcode = OP_NOP; start = 1'b1;
    ctl("drain1", 0, 1, 1, 0);
    check("drain1_halted", halted, 0);
    step(); start = 1'b0;
    ctl("drain2", 0, 1, 1, 0);
    step();
    check("drain3_halted", halted, 0);
    step();
    check("halted", halted, 1);
    ctl("halted_ctl", 0, 0, 0, 0);
    check("halt_bc", bubble_count, 3);
    step();
    check("halted_hold", halted, 1);
    start = 1'b1; step(); start = 1'b0;
    ctl("restart", 1, 1, 0, 0);
    check("restart_halted", halted, 0);
    id_opcode = OP_HALT; step(); id_opcode = OP_NOP;
    ex_branch_taken = 1'b1;
    ctl("drain_br", 1, 1, 1, 1);
    step(); ex_branch_taken = 1'b0;
    check("drain_br_bc", bubble_count, 5);
    ctl("drain_br_run", 1, 1, 0, 0);
    step();
    check("drain_br_halted", halted, 0);
    id_opcode = OP_HALT; id_ra = 3'd2; mem_wr = 1'b1; mem_rd = 3'd2;
    step(); quiet();
    check("pre_rst_fwd", fwd_a, 2'b10);
    reset = 1'b0;
    ctl("rst_drain", 0, 0, 1, 1);
    check("rst_drain_fwd", fwd_a, 2'b00);
    check("rst_drain_bc", bubble_count, 0);
    check("rst_drain_halted", halted, 0);
    step(); reset = 1'b1; step();
    ctl("rst_idle", 0, 0, 1, 1);
    start = 1'b1; step(); start = 1'b0;
    ctl("rst_start", 1, 1, 0, 0);
    ex_branch_taken = 1'b1;
    repeat (32767) step();
    check("sat_fffe", bubble_count, 16'hFFFE);
    step();
    check("sat_br", bubble_count, 16'hFFFF);
    quiet(); load_use_in();
    ctl("sat_stall", 0, 0, 0, 1);
    step();
    check("sat_stall_bc", bubble_count, 16'hFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
